// File: rtl/gdo_arbiter.sv
// gdo_arbiter: round-robin front end sharing one signed Q8.8 add/sub/mult
// datapath between N_REQ requesters, one operation in flight at a time.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req_valid[i]      requester i has an operation pending
//   req_ready[i]      one-hot combinational accept (only in IDLE)
//   req_op/a/b        per-requester op code and operands, packed by index
//   rsp_valid/ready   response handshake; rsp_* held until accepted
//   rsp_id            index of the requester the response belongs to
//   rsp_data          result (0 on illegal op)
//   rsp_err           1 when the op code was illegal (pow)
//   busy              FSM not in IDLE
//   op_count          completed responses, wraps at 16 bits
module gdo_arbiter #(
    parameter int unsigned N_REQ    = 3,
    parameter int unsigned DW       = 16,
    parameter int unsigned MULT_LAT = 2
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [N_REQ-1:0]                             req_valid,
    output logic [N_REQ-1:0]                             req_ready,
    input  logic [2*N_REQ-1:0]                           req_op,
    input  logic [DW*N_REQ-1:0]                          req_a,
    input  logic [DW*N_REQ-1:0]                          req_b,
    output logic                                         rsp_valid,
    input  logic                                         rsp_ready,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] rsp_id,
    output logic [DW-1:0]                                rsp_data,
    output logic                                         rsp_err,
    output logic                                         busy,
    output logic [15:0]                                  op_count
);

    localparam int unsigned IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW   = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam int unsigned FRAC = 8;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MULT = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [1:0]        op_r, op_d;
    logic [DW-1:0]     a_r, a_d;
    logic [DW-1:0]     b_r, b_d;
    logic [IDW-1:0]    id_r, id_d;
    logic [IDW-1:0]    last_grant, last_grant_d;
    logic              rsp_valid_d;
    logic [IDW-1:0]    rsp_id_d;
    logic [DW-1:0]     rsp_data_d;
    logic              rsp_err_d;
    logic              busy_d;
    logic [15:0]       op_count_d;

    logic              grant_found;
    logic [IDW-1:0]    grant_idx;
    logic [IDW-1:0]    cand;
    logic [1:0]        sel_op;
    logic [DW-1:0]     sel_a;
    logic [DW-1:0]     sel_b;

    logic signed [2*DW-1:0] prod;
    logic [DW-1:0]          alu_res;
    logic                   alu_err;

    // Round-robin search starting one past the last winner.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IDW'((32'(last_grant) + k) % N_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        sel_op = req_op[32'(grant_idx)*2 +: 2];
        sel_a  = req_a[32'(grant_idx)*DW +: DW];
        sel_b  = req_b[32'(grant_idx)*DW +: DW];
    end

    // Shared datapath; mult keeps the Q8.8 window of the full product (floor).
    always_comb begin
        prod    = (2*DW)'($signed(a_r)) * (2*DW)'($signed(b_r));
        alu_res = '0;
        alu_err = 1'b0;
        case (op_r)
            OP_ADD:  alu_res = a_r + b_r;
            OP_SUB:  alu_res = a_r - b_r;
            OP_MULT: alu_res = DW'(prod >>> FRAC);
            default: alu_err = 1'b1;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            op_r       <= '0;
            a_r        <= '0;
            b_r        <= '0;
            id_r       <= '0;
            last_grant <= IDW'(N_REQ - 1);
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            op_count   <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            op_r       <= op_d;
            a_r        <= a_d;
            b_r        <= b_d;
            id_r       <= id_d;
            last_grant <= last_grant_d;
            rsp_valid  <= rsp_valid_d;
            rsp_id     <= rsp_id_d;
            rsp_data   <= rsp_data_d;
            rsp_err    <= rsp_err_d;
            busy       <= busy_d;
            op_count   <= op_count_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        op_d         = op_r;
        a_d          = a_r;
        b_d          = b_r;
        id_d         = id_r;
        last_grant_d = last_grant;
        rsp_valid_d  = rsp_valid;
        rsp_id_d     = rsp_id;
        rsp_data_d   = rsp_data;
        rsp_err_d    = rsp_err;
        op_count_d   = op_count;
        req_ready    = '0;

        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready    = N_REQ'(1) << grant_idx;
                    op_d         = sel_op;
                    a_d          = sel_a;
                    b_d          = sel_b;
                    id_d         = grant_idx;
                    last_grant_d = grant_idx;
                    // Counter holds remaining EXEC cycles minus one.
                    cnt_d        = (sel_op == OP_MULT) ? CW'(MULT_LAT - 1) : '0;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = alu_res;
                    rsp_err_d   = alu_err;
                    rsp_id_d    = id_r;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_gdo_arbiter.sv
// Directed self-checking bench for gdo_arbiter (N_REQ=3, DW=16, MULT_LAT=2).
module tb_gdo_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [5:0]  req_op;
    logic [47:0] req_a;
    logic [47:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [15:0] op_count;

    int n_checks;
    int n_errors;
    int exp_cnt;

    gdo_arbiter #(.N_REQ(3), .DW(16), .MULT_LAT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        req_op[2*i +: 2] = op;
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    // One isolated operation with rsp_ready held high.
    task automatic run_op(input string tag, input int i, input logic [1:0] op,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_d, input logic exp_err, input int lat);
        int n;
        @(negedge clk);
        set_req(i, op, a, b);
        req_valid = 3'(1 << i);
        #1 check({tag, "_ready"}, 32'(req_ready), 32'(1 << i));
        n = 0;
        do begin
            @(negedge clk);
            req_valid = '0;
            n++;
        end while (!rsp_valid && n < 20);
        check({tag, "_lat"},  32'(n),        32'(1 + lat));
        check({tag, "_data"}, 32'(rsp_data), 32'(exp_d));
        check({tag, "_id"},   32'(rsp_id),   32'(i));
        check({tag, "_err"},  32'(rsp_err),  32'(exp_err));
        exp_cnt++;
        @(negedge clk);
        check({tag, "_cnt"},  32'(op_count), 32'(exp_cnt));
        check({tag, "_idle"}, 32'(busy),     32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic seen;
        n_checks  = 0;
        n_errors  = 0;
        exp_cnt   = 0;
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", 32'(rsp_valid), 32'(0));
        check("rst_busy",  32'(busy),      32'(0));
        check("rst_cnt",   32'(op_count),  32'(0));
        check("rst_data",  32'(rsp_data),  32'(0));
        check("rst_err",   32'(rsp_err),   32'(0));
        check("rst_id",    32'(rsp_id),    32'(0));
        check("rst_ready", 32'(req_ready), 32'(0));
        rst = 1'b0;

        // T1 add
        run_op("t1_add", 0, 2'd0, 16'h0180, 16'h0080, 16'h0200, 1'b0, 1);

        // T2 mult and sub wrap
        run_op("t2_mul3",   1, 2'd2, 16'h0180, 16'h0200, 16'h0300, 1'b0, 2);
        run_op("t2_mulneg", 1, 2'd2, 16'hFF00, 16'h0080, 16'hFF80, 1'b0, 2);
        run_op("t2_mulq",   1, 2'd2, 16'hFF80, 16'h0080, 16'hFFC0, 1'b0, 2);
        run_op("t2_floor",  1, 2'd2, 16'hFFFF, 16'h0080, 16'hFFFF, 1'b0, 2);
        run_op("t2_subwr",  1, 2'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1);

        // T3 round robin from a fresh reset
        @(negedge clk);
        rst = 1'b1;
        #2 rst = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 3; i++) set_req(i, 2'd0, 16'(i * 256), 16'h0001);
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!rsp_valid && n < 20);
            check($sformatf("t3_id%0d", k),   32'(rsp_id),   32'(k % 3));
            check($sformatf("t3_data%0d", k), 32'(rsp_data), 32'((k % 3) * 256 + 1));
            if (k == 5) req_valid = '0;
        end
        @(negedge clk);
        exp_cnt = 6;
        check("t3_cnt", 32'(op_count), 32'(6));

        // T4 illegal op
        run_op("t4_pow", 2, 2'd3, 16'h1234, 16'h0001, 16'h0000, 1'b1, 1);

        // T5 response back-pressure
        rsp_ready = 1'b0;
        @(negedge clk);
        set_req(0, 2'd2, 16'h0200, 16'h0300);
        req_valid = 3'b001;
        n = 0;
        do begin
            @(negedge clk);
            req_valid = '0;
            n++;
        end while (!rsp_valid && n < 20);
        check("t5_lat", 32'(n), 32'(3));
        set_req(1, 2'd0, 16'h0001, 16'h0001);
        set_req(2, 2'd0, 16'h0002, 16'h0002);
        req_valid = 3'b110;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check("t5_valid", 32'(rsp_valid), 32'(1));
            check("t5_data",  32'(rsp_data),  32'h0600);
            check("t5_id",    32'(rsp_id),    32'(0));
            check("t5_ready", 32'(req_ready), 32'(0));
            check("t5_busy",  32'(busy),      32'(1));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        exp_cnt++;
        check("t5_idle",   32'(busy),      32'(0));
        check("t5_rspclr", 32'(rsp_valid), 32'(0));
        check("t5_grant1", 32'(req_ready), 32'b010);
        check("t5_cnt",    32'(op_count),  32'(exp_cnt));
        req_valid = '0;

        // T6 reset during mult EXEC
        @(negedge clk);
        set_req(1, 2'd2, 16'h0100, 16'h0100);
        req_valid = 3'b010;
        #1 check("t6_ready", 32'(req_ready), 32'b010);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        #1;
        check("t6_valid", 32'(rsp_valid), 32'(0));
        check("t6_busy",  32'(busy),      32'(0));
        check("t6_cnt",   32'(op_count),  32'(0));
        check("t6_data",  32'(rsp_data),  32'(0));
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || busy) seen = 1'b1;
        end
        check("t6_noresp", 32'(seen), 32'(0));
        @(negedge clk);
        req_valid = 3'b111;
        #1 check("t6_grant0", 32'(req_ready), 32'b001);
        req_valid = '0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
